// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port among NM masters; ownership is held for the whole cyc tenure.
// Optional watchdog that aborts stalled cycles: define WB_ARB_TIMEOUT_EN.
module wb_master_arbiter #(
    parameter int unsigned NM      = 3,
    parameter int unsigned dw      = 32,
    parameter int unsigned aw      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic [NM-1:0]     m_cyc_i,
    input  logic [NM-1:0]     m_stb_i,
    input  logic [NM-1:0]     m_we_i,
    input  logic [NM*aw-1:0]  m_adr_i,
    input  logic [NM*dw-1:0]  m_dat_i,
    input  logic [NM*4-1:0]   m_sel_i,
    input  logic [NM*3-1:0]   m_cti_i,
    input  logic [NM*2-1:0]   m_bte_i,
    output logic [dw-1:0]     m_dat_o,
    output logic [NM-1:0]     m_ack_o,
    output logic [NM-1:0]     m_err_o,
    output logic [NM-1:0]     m_rty_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [aw-1:0]     s_adr_o,
    output logic [dw-1:0]     s_dat_o,
    output logic [3:0]        s_sel_o,
    output logic [2:0]        s_cti_o,
    output logic [1:0]        s_bte_o,
    input  logic [dw-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_rty_i,
    output logic [NM-1:0]     grant_o,
    output logic              timeout_o
);

    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWN = 2'd1, ST_ABORT = 2'd2} state_t;
`else
    typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;
`endif

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_owner, w_owner_nxt;
    logic [IW-1:0]   r_last,  w_last_nxt;
    logic [NM-1:0]   r_grant, w_grant_nxt;
    logic [IW-1:0]   w_pick;
    logic            w_found;
    logic            w_fire;

    logic            w_cyc_g, w_stb_g, w_we_g;
    logic [aw-1:0]   w_adr_g;
    logic [dw-1:0]   w_dat_g;
    logic [3:0]      w_sel_g;
    logic [2:0]      w_cti_g;
    logic [1:0]      w_bte_g;

    // Search starts one past the previous owner and wraps, so a just-served master ranks last.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = r_last;
        for (int unsigned k = 1; k <= NM; k++) begin
            idx = 32'(r_last) + k;
            if (idx >= NM) idx = idx - NM;
            if (!w_found && m_cyc_i[idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        w_cyc_g = 1'b0;
        w_stb_g = 1'b0;
        w_we_g  = 1'b0;
        w_adr_g = '0;
        w_dat_g = '0;
        w_sel_g = '0;
        w_cti_g = '0;
        w_bte_g = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (r_owner == IW'(i)) begin
                w_cyc_g = m_cyc_i[i];
                w_stb_g = m_stb_i[i];
                w_we_g  = m_we_i[i];
                w_adr_g = m_adr_i[i*aw +: aw];
                w_dat_g = m_dat_i[i*dw +: dw];
                w_sel_g = m_sel_i[i*4 +: 4];
                w_cti_g = m_cti_i[i*3 +: 3];
                w_bte_g = m_bte_i[i*2 +: 2];
            end
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (r_state == ST_OWN) begin
            s_cyc_o = w_cyc_g;
            s_stb_o = w_stb_g;
            s_we_o  = w_we_g;
            s_adr_o = w_adr_g;
            s_dat_o = w_dat_g;
            s_sel_o = w_sel_g;
            s_cti_o = w_cti_g;
            s_bte_o = w_bte_g;
            m_ack_o = r_grant & {NM{s_ack_i}};
            m_err_o = r_grant & {NM{s_err_i | w_fire}};
            m_rty_o = r_grant & {NM{s_rty_i}};
        end
    end

    assign m_dat_o   = s_dat_i;
    assign grant_o   = r_grant;
    assign timeout_o = w_fire;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt         = ST_OWN;
                    w_owner_nxt         = w_pick;
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_pick] = 1'b1;
                end
            end
            ST_OWN: begin
                if (!w_cyc_g) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_owner;
                    w_grant_nxt = '0;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (w_fire) begin
                    w_state_nxt = ST_ABORT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_ABORT: begin
                if (!w_cyc_g) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_owner;
                    w_grant_nxt = '0;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_last  <= IW'(NM - 1);
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] r_wdog;

    assign w_fire = (r_state == ST_OWN) && (r_wdog == 16'(TIMEOUT));

    // Counts consecutive unanswered strobe cycles; any break in the stall restarts it.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_wdog <= '0;
        end else if ((r_state == ST_OWN) && (w_state_nxt == ST_OWN) && s_stb_o &&
                     !(s_ack_i | s_err_i | s_rty_i)) begin
            r_wdog <= r_wdog + 16'd1;
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_fire = 1'b0;
`endif

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Round-robin arbiter that shares the single Wishbone interconnect master port between the CPU, DAQ and DSP bus masters. It sits between the masters' `wb_m_*` outputs and the bus matrix master port. Bus ownership is locked for the full `cyc` tenure of the granted master. An optional watchdog terminates stalled cycles with an error.

## Interface
Parameters:
- `NM`, 3: number of masters. Index 0 = cpu, 1 = daq, 2 = dsp.
- `dw`, 32: data width.
- `aw`, 32: address width.
- `TIMEOUT`, 255: watchdog limit in cycles, range 1..65535. Used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `wb_clk` in 1: single clock; everything is rising-edge.
- `wb_rst_n` in 1: asynchronous assert, active-low reset.
- `m_cyc_i`, `m_stb_i`, `m_we_i` in NM: per-master controls.
- `m_adr_i` in NM*aw: packed per-master addresses. Master i occupies `[i*aw +: aw]`.
- `m_dat_i` in NM*dw: packed per-master write data.
- `m_sel_i` in NM*4, `m_cti_i` in NM*3, `m_bte_i` in NM*2: packed per-master fields.
- `m_dat_o` out dw: slave read data, broadcast to all masters.
- `m_ack_o`, `m_err_o`, `m_rty_o` out NM: per-master responses. Only the granted bit can be 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1: interconnect master controls.
- `s_adr_o` aw, `s_dat_o` dw, `s_sel_o` 4, `s_cti_o` 3, `s_bte_o` 2 out: muxed request fields.
- `s_dat_i` in dw; `s_ack_i`, `s_err_i`, `s_rty_i` in 1: interconnect response.
- `grant_o` out NM: one-hot registered grant. All-zero when idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States:
  - IDLE: `grant_o` = 0. All `s_*` controls are 0.
  - OWN: one master granted. Its controls are muxed combinationally to `s_*`.
  - ABORT: watchdog fired. `s_cyc_o` and `s_stb_o` are forced 0.
- IDLE → OWN:
  - Taken on any `m_cyc_i` bit set.
  - Winner is the first requester in round-robin order, starting at index `(last+1) mod NM`.
  - `last` is the index of the previous owner. After reset `last` = NM-1, so master 0 has top priority.
- OWN → IDLE: taken when the owner's `m_cyc_i` drops. `last` ← owner.
- The arbiter always passes through one IDLE cycle between owners. There is no back-to-back regrant, including to the same master.
- In OWN:
  - `s_cyc_o` = `m_cyc_i[g]` and `s_stb_o` = `m_stb_i[g]`, where g is the owner index.
  - `m_ack_o[g]` = `s_ack_i`, `m_err_o[g]` = `s_err_i`, `m_rty_o[g]` = `s_rty_i`.
  - Response bits for all other masters are 0.
- Requests from non-granted masters are held pending and never dropped. Masters keep `cyc` asserted while waiting.
- Slave responses arriving in IDLE or ABORT are ignored and are not forwarded to any master.
- `m_dat_o` = `s_dat_i` at all times.
- All-zero `m_cyc_i` in IDLE: the arbiter stays in IDLE and `last` is unchanged.

## Timing
- Reset values: `grant_o`, `timeout_o` and all `s_*` / `m_*` response outputs = 0; state = IDLE; `last` = NM-1; watchdog counter = 0.
- Asserting `wb_rst_n` low mid-cycle drops `s_cyc_o` immediately, without waiting for a clock edge.
- Grant latency: `m_cyc_i[i]` rising in cycle N while in IDLE gives `grant_o[i]` = 1 and `s_cyc_o` = 1 in cycle N+1.
- Response path is combinational, with zero added latency. Only the grant is registered.
- Release: owner drops `cyc` in cycle M, so `s_cyc_o` = 0 in cycle M (combinational) and state = IDLE at M+1. The next owner is granted at M+2.
- `grant_o` stays constant for the whole tenure, including burst cycles (`cti` = 3'b010). Grant is never preempted.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined: a 16-bit counter is active.
  - Counter increments each OWN cycle with `s_stb_o` = 1 and no `s_ack_i`/`s_err_i`/`s_rty_i`.
  - Counter clears on any response, on `stb` low, or on leaving OWN.
  - When the counter equals `TIMEOUT`:
    - `m_err_o[g]` and `timeout_o` pulse for 1 cycle.
    - State goes to ABORT.
    - ABORT → IDLE when the owner drops `cyc`.
- `WB_ARB_TIMEOUT_EN` undefined: no counter is built, the ABORT state does not exist, and `timeout_o` is tied to 0. A stalled slave holds the bus indefinitely.

## Test plan
- **Single master:** cpu does a single read at 0x0000_0010 with a slave ack after 2 cycles. Required: `grant_o` = 3'b001 one cycle after `cyc`, and the cpu receives `m_ack_o[0]` with `s_dat_i` = 0xDEADBEEF.
- **Simultaneous request:** all three masters raise `cyc` in the same cycle from reset, each doing one transfer. Required grant order: 001 → (IDLE) → 010 → (IDLE) → 100, with exactly one IDLE cycle between owners.
- **Fairness:** cpu re-requests continuously while dsp requests. Required grants: cpu, dsp, cpu, dsp. The cpu never wins twice in a row while dsp is pending.
- **Burst hold:** daq runs a 4-beat incrementing burst (`cti` 010×3, then 111) while the cpu requests. Required: `grant_o` = 010 for all 4 acks, then cpu granted 2 cycles after daq drops `cyc`.
- **Watchdog:** build with `WB_ARB_TIMEOUT_EN` and `TIMEOUT` = 8; dsp strobes and the slave never answers. Required: `m_err_o[2]` and `timeout_o` high in the 9th stalled cycle, then `s_cyc_o` = 0.
- **Reset mid-transfer:** pull `wb_rst_n` low during a cpu write. Required: `s_cyc_o` and `grant_o` drop to 0 at once, and after release master 0 has top priority again.
